// File: rtl/tape_csw_player.sv
// rtl/tape_csw_player.sv - CSW pulse-length stream to cassette square wave for tape_in
module tape_csw_player #(
  parameter int unsigned CLK_HZ    = 64000000,
  parameter int unsigned SAMPLE_HZ = 44100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       motor,
  input  logic       play,
  input  logic       flush,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tape_in,
  output logic       running,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXT0,
    S_EXT1,
    S_EXT2,
    S_EXT3,
    S_COUNT
  } state_t;

  localparam logic [32:0] SAMPLE_INC = 33'(SAMPLE_HZ);
  localparam logic [32:0] CLK_WRAP   = 33'(CLK_HZ);

  state_t      state, state_d;
  logic [31:0] acc;
  logic [31:0] count;
  logic [23:0] len;
  logic [32:0] acc_sum;
  logic [31:0] ext_len;
  logic        run;
  logic        tick;
  logic        xfer;
  logic        fetching;

  assign run      = motor & play;
  assign acc_sum  = {1'b0, acc} + SAMPLE_INC;
  assign tick     = run && (acc_sum >= CLK_WRAP);
  assign xfer     = data_valid & data_ready;
  assign ext_len  = {data, len};
  assign running  = run & (state != S_IDLE);
  assign fetching = (state == S_FETCH) || (state == S_EXT0) || (state == S_EXT1) ||
                    (state == S_EXT2) || (state == S_EXT3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    data_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        data_ready = run;
        if (xfer) state_d = (data == 8'd0) ? S_EXT0 : S_COUNT;
      end
      S_EXT0: begin
        data_ready = run;
        if (xfer) state_d = S_EXT1;
      end
      S_EXT1: begin
        data_ready = run;
        if (xfer) state_d = S_EXT2;
      end
      S_EXT2: begin
        data_ready = run;
        if (xfer) state_d = S_EXT3;
      end
      S_EXT3: begin
        data_ready = run;
        if (xfer) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (tick && count == 32'd1) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath: sample accumulator, pulse counter, escape length assembly, output level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= 32'd0;
      count    <= 32'd0;
      len      <= 24'd0;
      tape_in  <= 1'b0;
      underrun <= 1'b0;
    end else if (flush) begin
      acc      <= 32'd0;
      count    <= 32'd0;
      len      <= 24'd0;
      tape_in  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (run) acc <= tick ? 32'(acc_sum - CLK_WRAP) : acc_sum[31:0];

      if (xfer) begin
        underrun <= 1'b0;
        case (state)
          S_FETCH: if (data != 8'd0) count <= {24'd0, data};
          S_EXT0:  len[7:0]   <= data;
          S_EXT1:  len[15:8]  <= data;
          S_EXT2:  len[23:16] <= data;
          S_EXT3:  count <= (ext_len == 32'd0) ? 32'd1 : ext_len;
          default: ;
        endcase
      end else if (run && fetching && !data_valid) begin
        underrun <= 1'b1;
      end

      // Toggle lands on the tick edge that consumes the last sample of the pulse.
      if (state == S_COUNT && tick) begin
        count <= count - 32'd1;
        if (count == 32'd1) tape_in <= ~tape_in;
      end
    end
  end

endmodule
